// File: rtl/alu_defines.sv
// alu_defines: operation encodings shared between decode and the execute-side
// blocks. Only the CSR operation codes are needed by csr_file.
package alu_defines;

  localparam logic [1:0] CSR_OP_NONE  = 2'd0;
  localparam logic [1:0] CSR_OP_WRITE = 2'd1;
  localparam logic [1:0] CSR_OP_SET   = 2'd2;
  localparam logic [1:0] CSR_OP_CLEAR = 2'd3;

endpackage

// File: rtl/csr_pkg.sv
// csr_pkg: machine-mode CSR addresses, mstatus bit positions, trap cause codes
// and the mtvec mode encoding used by csr_file and its testbench.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  localparam logic [4:0] CAUSE_ILLEGAL_INSTR = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT    = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M       = 5'd11;
  localparam logic [4:0] CAUSE_IRQ_LOCAL0    = 5'd16;

  typedef enum logic {
    MTVEC_DIRECT   = 1'b0,
    MTVEC_VECTORED = 1'b1
  } mtvec_mode_e;

endpackage

// File: rtl/csr_counter.sv
// csr_counter: W-bit free-running counter (mcycle / minstret) with 32-bit
// half-word write ports. A write to either half wins over the increment for
// that cycle. For W == 32 there is no upper half and wr_hi_i has no effect.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   inc_i        advance the count by one this cycle
//   wr_lo_i      replace bits [31:0] with wdata_i
//   wr_hi_i      replace bits [W-1:32] with wdata_i (W > 32 only)
//   wdata_i      write data
//   count_o      current count
module csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         wr_lo_i,
  input  logic         wr_hi_i,
  input  logic [31:0]  wdata_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_d;

  generate
    if (W > 32) begin : g_wide
      always_comb begin
        count_d = count_o;
        if (wr_lo_i)
          count_d = {count_o[W-1:32], wdata_i};
        else if (wr_hi_i)
          count_d = {wdata_i[W-33:0], count_o[31:0]};
        else if (inc_i)
          count_d = count_o + W'(1);
      end
    end else begin : g_narrow
      always_comb begin
        count_d = count_o;
        if (wr_lo_i)
          count_d = wdata_i;
        else if (inc_i)
          count_d = count_o + W'(1);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_o <= '0;
    else
      count_o <= count_d;
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with trap entry, MRET and local interrupts.
// Serves CSR instructions from decode/execute, records trap state, restores
// it on MRET and hands the trap vector and mepc to fetch.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   op_i/addr_i     CSR operation and address; wdata_i is the operand
//   rdata_o         combinational read of addr_i
//   illegal_o       op on an unmapped address or a write-class op on a RO CSR
//   retire_i        instruction retired (minstret increment)
//   trap_i          take a trap; trap_int_i/cause_i/pc_i describe it
//   mret_i          MRET executing
//   irq_i           level-sensitive local interrupt lines (mip bit 16+k)
//   irq_pending_o   mstatus.MIE & |(mip & mie)
//   trap_vec_o      trap target PC
//   epc_o           mepc
module csr_file #(
  parameter int          COUNTER_W   = 64,
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         op_i,
  input  logic [11:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               illegal_o,
  input  logic               retire_i,
  input  logic               trap_i,
  input  logic               trap_int_i,
  input  logic [4:0]         cause_i,
  input  logic [31:0]        pc_i,
  input  logic               mret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_pending_o,
  output logic [31:0]        trap_vec_o,
  output logic [31:0]        epc_o
);

  import csr_pkg::*;
  import alu_defines::*;

  logic               mstatus_mie_q;
  logic               mstatus_mpie_q;
  logic [NUM_IRQ-1:0] irq_en_q;
  logic [NUM_IRQ-1:0] irq_pend_q;
  logic [31:0]        mtvec_q;
  logic [31:0]        mscratch_q;
  logic [31:0]        mepc_q;
  logic [31:0]        mcause_q;

  logic [COUNTER_W-1:0] mcycle;
  logic [COUNTER_W-1:0] minstret;
  logic [63:0]          mcycle_x;
  logic [63:0]          minstret_x;

  logic [31:0] mstatus_rd;
  logic [31:0] csr_wdata;
  logic        mapped;
  logic        read_only;
  logic        csr_we;

  // Place the local interrupt vector at bits 16+k of a 32-bit CSR view.
  function automatic logic [31:0] irq_field(input logic [NUM_IRQ-1:0] v);
    logic [31:0] r;
    r = '0;
    r[16 +: NUM_IRQ] = v;
    return r;
  endfunction

  // Zero-extended counter views; the upper half reads 0 when COUNTER_W == 32.
  assign mcycle_x   = 64'(mcycle);
  assign minstret_x = 64'(minstret);

  always_comb begin
    mstatus_rd = 32'h0000_1800;  // MPP is fixed at machine mode
    mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
  end

  always_comb begin
    rdata_o   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (addr_i)
      CSR_MSTATUS:   rdata_o = mstatus_rd;
      CSR_MIE:       rdata_o = irq_field(irq_en_q);
      CSR_MTVEC:     rdata_o = mtvec_q;
      CSR_MSCRATCH:  rdata_o = mscratch_q;
      CSR_MEPC:      rdata_o = mepc_q;
      CSR_MCAUSE:    rdata_o = mcause_q;
      CSR_MIP:       begin rdata_o = irq_field(irq_pend_q); read_only = 1'b1; end
      CSR_MCYCLE:    rdata_o = mcycle_x[31:0];
      CSR_MCYCLEH:   rdata_o = mcycle_x[63:32];
      CSR_MINSTRET:  rdata_o = minstret_x[31:0];
      CSR_MINSTRETH: rdata_o = minstret_x[63:32];
      CSR_CYCLE:     begin rdata_o = mcycle_x[31:0];    read_only = 1'b1; end
      CSR_CYCLEH:    begin rdata_o = mcycle_x[63:32];   read_only = 1'b1; end
      CSR_INSTRET:   begin rdata_o = minstret_x[31:0];  read_only = 1'b1; end
      CSR_INSTRETH:  begin rdata_o = minstret_x[63:32]; read_only = 1'b1; end
      default:       mapped = 1'b0;
    endcase
  end

  assign illegal_o = (op_i != CSR_OP_NONE) && (!mapped || read_only);

  always_comb begin
    case (op_i)
      CSR_OP_WRITE: csr_wdata = wdata_i;
      CSR_OP_SET:   csr_wdata = rdata_o | wdata_i;
      CSR_OP_CLEAR: csr_wdata = rdata_o & ~wdata_i;
      default:      csr_wdata = rdata_o;
    endcase
  end

  // A trap or MRET in the same cycle drops the CSR write entirely.
  assign csr_we = (op_i != CSR_OP_NONE) && !illegal_o && !trap_i && !mret_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      irq_en_q       <= '0;
      irq_pend_q     <= '0;
      mtvec_q        <= MTVEC_RESET & ~32'h2;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      irq_pend_q <= irq_i;
      if (trap_i) begin
        mepc_q         <= pc_i & ~32'h3;
        mcause_q       <= {trap_int_i, 26'b0, cause_i};
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (csr_we) begin
        case (addr_i)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= csr_wdata[MSTATUS_MIE_BIT];
            mstatus_mpie_q <= csr_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:      irq_en_q   <= csr_wdata[16 +: NUM_IRQ];
          CSR_MTVEC:    mtvec_q    <= csr_wdata & ~32'h2;
          CSR_MSCRATCH: mscratch_q <= csr_wdata;
          CSR_MEPC:     mepc_q     <= csr_wdata & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  csr_counter #(.W(COUNTER_W)) u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && (addr_i == CSR_MCYCLE)),
    .wr_hi_i (csr_we && (addr_i == CSR_MCYCLEH)),
    .wdata_i (csr_wdata),
    .count_o (mcycle)
  );

  csr_counter #(.W(COUNTER_W)) u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (retire_i),
    .wr_lo_i (csr_we && (addr_i == CSR_MINSTRET)),
    .wr_hi_i (csr_we && (addr_i == CSR_MINSTRETH)),
    .wdata_i (csr_wdata),
    .count_o (minstret)
  );

  assign irq_pending_o = mstatus_mie_q & |(irq_pend_q & irq_en_q);

  // Vectored mode only offsets interrupts; exceptions always go to the base.
  always_comb begin
    if (mtvec_mode_e'(mtvec_q[0]) == MTVEC_VECTORED && trap_int_i)
      trap_vec_o = {mtvec_q[31:2], 2'b00} + {25'b0, cause_i, 2'b00};
    else
      trap_vec_o = {mtvec_q[31:2], 2'b00};
  end

  assign epc_o = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Testbench for csr_file: directed stimulus pushes expected values into a
// scoreboard queue tagged with the cycle they belong to; a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_csr_file;

  import csr_pkg::*;
  import alu_defines::*;

  localparam int K_RDATA = 0;
  localparam int K_ILL   = 1;
  localparam int K_PEND  = 2;
  localparam int K_TVEC  = 3;
  localparam int K_EPC   = 4;
  localparam int K_RD32  = 5;
  localparam int K_ILL32 = 6;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } sb_item_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  op;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        illegal;
  logic        retire;
  logic        trap;
  logic        trap_int;
  logic [4:0]  cause;
  logic [31:0] pc;
  logic        mret;
  logic [3:0]  irq;
  logic        irq_pending;
  logic [31:0] trap_vec;
  logic [31:0] epc;

  logic [1:0]  op32;
  logic [11:0] addr32;
  logic [31:0] wdata32;
  logic [31:0] rdata32;
  logic        illegal32;
  logic [1:0]  irq32;
  logic        irq_pending32;
  logic [31:0] trap_vec32;
  logic [31:0] epc32;

  sb_item_t    sb[$];
  int          cyc;
  int          checks;
  int          errors;
  sb_item_t    mon_e;
  logic [31:0] mon_act;

  csr_file #(.COUNTER_W(64), .NUM_IRQ(4), .MTVEC_RESET(32'h0000_1000)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .illegal_o(illegal), .retire_i(retire), .trap_i(trap),
    .trap_int_i(trap_int), .cause_i(cause), .pc_i(pc), .mret_i(mret),
    .irq_i(irq), .irq_pending_o(irq_pending), .trap_vec_o(trap_vec), .epc_o(epc)
  );

  csr_file #(.COUNTER_W(32), .NUM_IRQ(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .op_i(op32), .addr_i(addr32), .wdata_i(wdata32),
    .rdata_o(rdata32), .illegal_o(illegal32), .retire_i(1'b0), .trap_i(1'b0),
    .trap_int_i(1'b0), .cause_i(5'd0), .pc_i(32'h0), .mret_i(1'b0),
    .irq_i(irq32), .irq_pending_o(irq_pending32), .trap_vec_o(trap_vec32), .epc_o(epc32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every falling edge, consume the expectations for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_RDATA: mon_act = rdata;
        K_ILL:   mon_act = {31'b0, illegal};
        K_PEND:  mon_act = {31'b0, irq_pending};
        K_TVEC:  mon_act = trap_vec;
        K_EPC:   mon_act = epc;
        K_RD32:  mon_act = rdata32;
        default: mon_act = {31'b0, illegal32};
      endcase
      checks = checks + 1;
      if (mon_e.cyc != cyc) begin
        errors = errors + 1;
        $display("FAIL %s: sampled in cycle %0d, required cycle %0d", mon_e.name, cyc, mon_e.cyc);
      end else if (mon_act !== mon_e.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] val, input string name);
    sb.push_back('{cyc, kind, val, name});
  endtask

  task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
    op = o; addr = a; wdata = d;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] val, input string name);
    op = CSR_OP_NONE; addr = a; wdata = '0;
    expect_val(K_RDATA, val, name);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    op = CSR_OP_NONE; addr = CSR_MSTATUS; wdata = '0;
    retire = 0; trap = 0; trap_int = 0; cause = '0; pc = '0; mret = 0; irq = '0;
    op32 = CSR_OP_NONE; addr32 = CSR_MCYCLE; wdata32 = '0; irq32 = '0;
    step(); step();
    rst_n = 1'b1;

    // 1. reset values and free-running mcycle
    rd(CSR_MCYCLE, 32'h0, "reset_mcycle");
    expect_val(K_EPC, 32'h0, "reset_epc");
    expect_val(K_PEND, 32'h0, "reset_pending");
    step();
    rd(CSR_MSTATUS, 32'h1800, "reset_mstatus");
    step();
    rd(CSR_MTVEC, 32'h1000, "reset_mtvec");
    step();
    repeat (7) step();
    rd(CSR_MCYCLE, 32'd10, "mcycle_after_10");
    expect_val(K_RD32, 32'd10, "mcycle32_after_10");
    step();
    rd(CSR_CYCLE, 32'd11, "cycle_shadow");
    step();

    // 2. interrupt enable and 1-cycle mip latency
    csr(CSR_OP_WRITE, CSR_MSTATUS, 32'h8);
    expect_val(K_ILL, 32'h0, "mstatus_write_legal");
    step();
    csr(CSR_OP_SET, CSR_MIE, 32'h0001_0000);
    step();
    rd(CSR_MSTATUS, 32'h1808, "mstatus_mie_set");
    irq = 4'b0001;
    expect_val(K_PEND, 32'h0, "pending_same_cycle");
    step();
    rd(CSR_MIP, 32'h0001_0000, "mip_irq0");
    expect_val(K_PEND, 32'h1, "pending_next_cycle");
    step();

    // 3. vectored trap entry and MRET
    csr(CSR_OP_WRITE, CSR_MTVEC, 32'h103);
    step();
    rd(CSR_MTVEC, 32'h101, "mtvec_bit1_zero");
    step();
    trap = 1; trap_int = 1; cause = 5'd16; pc = 32'h1236;
    rd(CSR_MEPC, 32'h0, "mepc_before_trap");
    expect_val(K_TVEC, 32'h140, "trap_vec_vectored");
    step();
    trap = 0; trap_int = 0;
    rd(CSR_MEPC, 32'h1234, "mepc_after_trap");
    expect_val(K_EPC, 32'h1234, "epc_after_trap");
    expect_val(K_PEND, 32'h0, "pending_masked_in_trap");
    step();
    rd(CSR_MCAUSE, 32'h8000_0010, "mcause_irq16");
    step();
    rd(CSR_MSTATUS, 32'h1880, "mstatus_in_trap");
    step();
    mret = 1;
    rd(CSR_MSTATUS, 32'h1880, "mstatus_during_mret");
    step();
    mret = 0;
    rd(CSR_MSTATUS, 32'h1888, "mstatus_after_mret");
    expect_val(K_PEND, 32'h1, "pending_after_mret");
    step();

    // 4. 64-bit counter carry, minstret, SET/CLEAR
    csr(CSR_OP_WRITE, CSR_MCYCLE, 32'hFFFF_FFFF);
    step();
    csr(CSR_OP_WRITE, CSR_MCYCLEH, 32'h0);
    expect_val(K_ILL, 32'h0, "mcycleh_write_legal");
    step();
    rd(CSR_MCYCLE, 32'hFFFF_FFFF, "mcycle_held_by_write");
    step();
    rd(CSR_MCYCLE, 32'h0, "mcycle_carry_lo");
    step();
    rd(CSR_MCYCLEH, 32'h1, "mcycleh_carry_hi");
    step();
    rd(CSR_CYCLEH, 32'h1, "cycleh_shadow");
    step();
    csr(CSR_OP_WRITE, CSR_MINSTRET, 32'd5);
    retire = 1;
    step();
    rd(CSR_MINSTRET, 32'd5, "minstret_write_wins");
    step();
    rd(CSR_INSTRET, 32'd6, "instret_shadow");
    step();
    retire = 0;
    rd(CSR_MINSTRET, 32'd7, "minstret_count");
    step();
    csr(CSR_OP_WRITE, CSR_MSCRATCH, 32'h0000_F0F0);
    step();
    csr(CSR_OP_CLEAR, CSR_MSCRATCH, 32'h0000_00F0);
    step();
    csr(CSR_OP_SET, CSR_MSCRATCH, 32'h0000_0001);
    step();
    rd(CSR_MSCRATCH, 32'h0000_F001, "mscratch_set_clear");
    step();

    // 4b. COUNTER_W = 32 wrap and empty upper half
    op32 = CSR_OP_WRITE; addr32 = CSR_MCYCLE; wdata32 = 32'hFFFF_FFFE;
    step();
    op32 = CSR_OP_NONE;
    expect_val(K_RD32, 32'hFFFF_FFFE, "m32_written");
    step();
    expect_val(K_RD32, 32'hFFFF_FFFF, "m32_max");
    step();
    expect_val(K_RD32, 32'h0, "m32_wrap");
    step();
    op32 = CSR_OP_WRITE; addr32 = CSR_MCYCLEH; wdata32 = 32'h55;
    expect_val(K_ILL32, 32'h0, "m32_mcycleh_write_legal");
    step();
    op32 = CSR_OP_NONE;
    expect_val(K_RD32, 32'h0, "m32_mcycleh_zero");
    step();
    addr32 = CSR_CYCLEH;
    expect_val(K_RD32, 32'h0, "m32_cycleh_zero");
    step();

    // 5. trap beats CSR write; illegal accesses
    trap = 1; trap_int = 0; cause = 5'd2; pc = 32'h2000;
    csr(CSR_OP_WRITE, CSR_MEPC, 32'hAAAA);
    expect_val(K_TVEC, 32'h100, "trap_vec_exception");
    expect_val(K_ILL, 32'h0, "mepc_write_legal");
    step();
    trap = 0;
    rd(CSR_MEPC, 32'h2000, "mepc_trap_over_write");
    step();
    rd(CSR_MCAUSE, 32'h2, "mcause_exception");
    step();
    rd(CSR_MSTATUS, 32'h1880, "mstatus_exception");
    step();
    csr(CSR_OP_WRITE, CSR_MIP, 32'hFFFF_FFFF);
    expect_val(K_ILL, 32'h1, "mip_write_illegal");
    step();
    rd(CSR_MIP, 32'h0001_0000, "mip_unchanged");
    step();
    csr(CSR_OP_SET, CSR_CYCLE, 32'h0);
    expect_val(K_ILL, 32'h1, "cycle_set0_illegal");
    step();
    csr(CSR_OP_WRITE, 12'h7C0, 32'h1);
    expect_val(K_ILL, 32'h1, "unmapped_illegal");
    expect_val(K_RDATA, 32'h0, "unmapped_reads_zero");
    step();
    mret = 1;
    csr(CSR_OP_WRITE, CSR_MEPC, 32'h5555);
    step();
    mret = 0;
    rd(CSR_MEPC, 32'h2000, "mepc_mret_over_write");
    step();
    rd(CSR_MSTATUS, 32'h1888, "mstatus_after_mret2");
    expect_val(K_PEND, 32'h1, "pending_before_reset");
    step();

    // 6. asynchronous reset mid-operation
    rst_n = 1'b0;
    rd(CSR_MSTATUS, 32'h1800, "rst_mstatus");
    expect_val(K_PEND, 32'h0, "rst_pending");
    expect_val(K_EPC, 32'h0, "rst_epc");
    step();
    rd(CSR_MIE, 32'h0, "rst_mie");
    step();
    rd(CSR_MTVEC, 32'h1000, "rst_mtvec");
    step();
    rd(CSR_MEPC, 32'h0, "rst_mepc");
    step();
    rd(CSR_MCAUSE, 32'h0, "rst_mcause");
    step();
    rd(CSR_MIP, 32'h0, "rst_mip");
    step();
    rd(CSR_MSCRATCH, 32'h0, "rst_mscratch");
    step();
    rd(CSR_MCYCLE, 32'h0, "rst_mcycle");
    step();
    rd(CSR_MINSTRET, 32'h0, "rst_minstret");
    step();
    irq = '0;
    rst_n = 1'b1;
    step(); step();

    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
